// File: rtl/midi_msg_parser.sv
// midi_msg_parser
//   Decodes MIDI channel-voice messages from the byte stream of the serial
//   receiver. Handles running status, real-time bytes arriving inside a
//   message, and framing-error recovery. It emits a one-cycle Note-On or
//   Note-Off event and shows the last event on the board LEDs.
//
// Ports
//   clk         system clock, shared with the byte receiver
//   rst_n       synchronous active-low reset
//   byte_valid  one-cycle strobe; byte_data and byte_err are valid in this cycle
//   byte_data   received byte
//   byte_err    framing error on this byte; the byte is discarded
//   evt_valid   one-cycle event strobe, one cycle after the completing byte
//   evt_on      1 = Note-On, 0 = Note-Off
//   evt_chan    event channel 0-15
//   evt_note    event note number
//   evt_vel     event velocity
//   LED         {evt_on, evt_note} of the last emitted event
//   err_cnt     framing-error count, saturating at 255
module midi_msg_parser #(
    parameter bit         CHAN_FILTER_EN = 1'b0,
    parameter logic [3:0] CHANNEL        = 4'd0,
    parameter bit         VEL0_OFF       = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       byte_err,
    output logic       evt_valid,
    output logic       evt_on,
    output logic [3:0] evt_chan,
    output logic [6:0] evt_note,
    output logic [6:0] evt_vel,
    output logic [7:0] LED,
    output logic [7:0] err_cnt
);

    // IDLE: no running status. D1/D2: waiting for the first or second data byte.
    typedef enum logic [1:0] {IDLE, D1, D2} state_t;

    state_t     state, state_nxt;
    logic [7:0] run_status, run_status_nxt;
    logic [6:0] d1, d1_nxt;
    logic       emit;

    // Byte classes
    logic is_data, is_chan, is_sys, is_rt;
    assign is_data = ~byte_data[7];
    assign is_rt   = (byte_data[7:3] == 5'b11111);
    assign is_sys  = (byte_data[7:3] == 5'b11110);
    assign is_chan = byte_data[7] && (byte_data[7:4] != 4'hF);

    // Properties of the message selected by the running status
    logic two_data, note_msg, chan_ok, on_nxt;
    assign two_data = (run_status[7:4] != 4'hC) && (run_status[7:4] != 4'hD);
    assign note_msg = (run_status[7:4] == 4'h8) || (run_status[7:4] == 4'h9);
    assign chan_ok  = !CHAN_FILTER_EN || (run_status[3:0] == CHANNEL);
    // A Note-On with velocity 0 is the common shorthand for Note-Off.
    assign on_nxt   = (run_status[7:4] == 4'h9) &&
                      !(VEL0_OFF && (byte_data[6:0] == 7'd0));

    // Next-state logic. A real-time byte falls through with every default
    // kept, so it can arrive between any two bytes of a message.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_nxt      = state;
        run_status_nxt = run_status;
        d1_nxt         = d1;
        emit           = 1'b0;
        if (byte_valid) begin
            if (byte_err) begin
                state_nxt      = IDLE;
                run_status_nxt = 8'h00;
            end else if (is_rt) begin
                state_nxt = state;
            end else if (is_chan) begin
                run_status_nxt = byte_data;
                state_nxt      = D1;
            end else if (is_sys) begin
                // SysEx payload that follows is data in IDLE and gets dropped.
                state_nxt      = IDLE;
                run_status_nxt = 8'h00;
            end else if (is_data) begin
                unique case (state)
                    IDLE: state_nxt = IDLE;
                    D1: begin
                        // A single-data message completes here and keeps D1.
                        if (two_data) begin
                            d1_nxt    = byte_data[6:0];
                            state_nxt = D2;
                        end
                    end
                    D2: begin
                        state_nxt = D1;
                        emit      = note_msg && chan_ok;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments, so each register
        // samples values from before the edge no matter how statements are ordered.
        if (!rst_n) begin
            state      <= IDLE;
            run_status <= 8'h00;
            d1         <= 7'h00;
            evt_valid  <= 1'b0;
            evt_on     <= 1'b0;
            evt_chan   <= 4'd0;
            evt_note   <= 7'h00;
            evt_vel    <= 7'h00;
            LED        <= 8'h00;
            err_cnt    <= 8'h00;
        end else begin
            state      <= state_nxt;
            run_status <= run_status_nxt;
            d1         <= d1_nxt;
            evt_valid  <= emit;
            if (emit) begin
                evt_on   <= on_nxt;
                evt_chan <= run_status[3:0];
                evt_note <= d1;
                evt_vel  <= byte_data[6:0];
                LED      <= {on_nxt, d1};
            end
            if (byte_valid && byte_err && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Testbench for midi_msg_parser. Two instances share one byte stream.
// u_dut uses the default parameters. u_flt filters for channel 2 and reports
// a velocity-0 Note-On as a Note-On. A message-level reference model
// predicts both instances, and a compare process checks every output on
// each falling edge. Directed sequences carry literal expectations.
module tb_midi_msg_parser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_err = 1'b0;

    logic       a_valid, a_on, b_valid, b_on;
    logic [3:0] a_chan, b_chan;
    logic [6:0] a_note, a_vel, b_note, b_vel;
    logic [7:0] a_led, a_err, b_led, b_err;

    always #5 clk = ~clk;

    midi_msg_parser u_dut (
        .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_err(byte_err), .evt_valid(a_valid), .evt_on(a_on), .evt_chan(a_chan),
        .evt_note(a_note), .evt_vel(a_vel), .LED(a_led), .err_cnt(a_err)
    );

    midi_msg_parser #(.CHAN_FILTER_EN(1'b1), .CHANNEL(4'd2), .VEL0_OFF(1'b0)) u_flt (
        .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_err(byte_err), .evt_valid(b_valid), .evt_on(b_on), .evt_chan(b_chan),
        .evt_note(b_note), .evt_vel(b_vel), .LED(b_led), .err_cnt(b_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (message level) ----------------
    typedef struct packed {
        logic [7:0] rs;      // running status byte, 0 = none
        int         n;       // data bytes collected for the current message
        logic [6:0] first;   // first data byte of the current message
        logic       ev;
        logic       on;
        logic [3:0] ch;
        logic [6:0] note;
        logic [6:0] vel;
        logic [7:0] led;
        logic [7:0] err;
    } model_t;

    function automatic model_t m_reset();
        model_t m;
        m = '0;
        return m;
    endfunction

    function automatic model_t m_step(model_t m, logic [7:0] b, logic e,
                                      bit filt, logic [3:0] chan, bit v0off);
        int need;
        m.ev = 1'b0;
        if (e) begin
            m.rs = 8'h00; m.n = 0;
            if (m.err != 8'd255) m.err = m.err + 8'd1;
        end else if (b >= 8'hF8) begin
            // real-time: no effect on message decoding
        end else if (b >= 8'hF0) begin
            m.rs = 8'h00; m.n = 0;
        end else if (b >= 8'h80) begin
            m.rs = b; m.n = 0;
        end else if (m.rs != 8'h00) begin
            need = (m.rs[7:4] == 4'hC || m.rs[7:4] == 4'hD) ? 1 : 2;
            if (m.n == 0) m.first = b[6:0];
            m.n++;
            if (m.n == need) begin
                m.n = 0;
                if (need == 2 && (m.rs[7:4] == 4'h8 || m.rs[7:4] == 4'h9) &&
                    (!filt || m.rs[3:0] == chan)) begin
                    m.ev   = 1'b1;
                    m.on   = (m.rs[7:4] == 4'h9) && !(v0off && b[6:0] == 7'd0);
                    m.ch   = m.rs[3:0];
                    m.note = m.first;
                    m.vel  = b[6:0];
                    m.led  = {m.on, m.first};
                end
            end
        end
        return m;
    endfunction

    model_t m_a, m_b;
    bit armed = 1'b0;

    // Outputs are checked on the falling edge, against the prediction made at
    // the previous falling edge from the inputs that the rising edge between them captured.
    always @(negedge clk) begin
        if (armed) begin
            check("a.evt_valid", a_valid, m_a.ev);
            check("a.evt_on",    a_on,    m_a.on);
            check("a.evt_chan",  a_chan,  m_a.ch);
            check("a.evt_note",  a_note,  m_a.note);
            check("a.evt_vel",   a_vel,   m_a.vel);
            check("a.LED",       a_led,   m_a.led);
            check("a.err_cnt",   a_err,   m_a.err);
            check("b.evt_valid", b_valid, m_b.ev);
            check("b.evt_on",    b_on,    m_b.on);
            check("b.evt_chan",  b_chan,  m_b.ch);
            check("b.evt_note",  b_note,  m_b.note);
            check("b.evt_vel",   b_vel,   m_b.vel);
            check("b.LED",       b_led,   m_b.led);
            check("b.err_cnt",   b_err,   m_b.err);
        end
        if (!rst_n) begin
            m_a = m_reset();
            m_b = m_reset();
            armed = 1'b1;
        end else if (byte_valid) begin
            m_a = m_step(m_a, byte_data, byte_err, 1'b0, 4'd0, 1'b1);
            m_b = m_step(m_b, byte_data, byte_err, 1'b1, 4'd2, 1'b0);
        end else begin
            m_a.ev = 1'b0;
            m_b.ev = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1. Drives one byte strobe, then idles for gap cycles
    // (gap 0 gives back-to-back strobes).
    task automatic send(input logic [7:0] b, input logic e, input int gap);
        byte_valid = 1'b1; byte_data = b; byte_err = e;
        @(posedge clk); #1;
        byte_valid = 1'b0; byte_err = 1'b0; byte_data = 8'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 50)      return {1'b0, 7'($urandom)};
        else if (r < 65) return {($urandom_range(0, 1) != 0) ? 4'h9 : 4'h8, 4'($urandom_range(0, 3))};
        else if (r < 73) return 8'hA0 + 8'($urandom_range(0, 79));
        else if (r < 77) return 8'hF0 + 8'($urandom_range(0, 7));
        else if (r < 85) return 8'hF8 + 8'($urandom_range(0, 7));
        else             return {1'b0, 7'($urandom)};
    endfunction

    initial begin
        @(posedge clk); #1;
        do_reset();
        check("reset.LED", a_led, 8'h00);
        check("reset.err_cnt", a_err, 8'h00);

        // 1: single Note-On
        send(8'h93, 0, 1); send(8'h3C, 0, 1); send(8'h64, 0, 0);
        check("t1.evt_valid", a_valid, 1'b1);
        check("t1.evt_chan", a_chan, 4'd3);
        check("t1.evt_note", a_note, 7'h3C);
        check("t1.evt_vel", a_vel, 7'h64);
        check("t1.LED", a_led, 8'hBC);
        @(posedge clk); #1;
        check("t1.evt_valid_drop", a_valid, 1'b0);

        // 2: running status, velocity 0 becomes Note-Off
        send(8'h90, 0, 1); send(8'h40, 0, 1); send(8'h50, 0, 0);
        check("t2.on1", a_on, 1'b1);
        check("t2.vel1", a_vel, 7'h50);
        send(8'h41, 0, 1); send(8'h00, 0, 0);
        check("t2.valid2", a_valid, 1'b1);
        check("t2.on2", a_on, 1'b0);
        check("t2.LED2", a_led, 8'h41);

        // 3: real-time interleave
        send(8'h90, 0, 0); send(8'hF8, 0, 1); send(8'h3C, 0, 0); send(8'hFE, 0, 1);
        send(8'h64, 0, 0);
        check("t3.valid", a_valid, 1'b1);
        check("t3.note", a_note, 7'h3C);
        check("t3.vel", a_vel, 7'h64);

        // 4: framing error mid-message
        do_reset();
        send(8'h90, 0, 1); send(8'h3C, 0, 1); send(8'h00, 1, 1); send(8'h64, 0, 0);
        check("t4.no_evt", a_valid, 1'b0);
        check("t4.err_cnt", a_err, 8'd1);
        send(8'h45, 0, 1); send(8'h20, 0, 0);
        check("t4.no_evt_rs", a_valid, 1'b0);

        // 5: channel filter (u_flt, channel 2)
        send(8'h92, 0, 1); send(8'h30, 0, 1); send(8'h10, 0, 0);
        check("t5.valid", b_valid, 1'b1);
        check("t5.LED", b_led, 8'hB0);
        send(8'h95, 0, 1); send(8'h30, 0, 1); send(8'h10, 0, 0);
        check("t5.filtered", b_valid, 1'b0);
        check("t5.LED_hold", b_led, 8'hB0);
        send(8'hC2, 0, 1); send(8'h05, 0, 0);
        check("t5.pgm_no_evt", b_valid, 1'b0);
        send(8'h92, 0, 1); send(8'h31, 0, 1); send(8'h11, 0, 0);
        check("t5.after_pgm", b_valid, 1'b1);
        check("t5.after_pgm_LED", b_led, 8'hB1);

        // 6: reset mid-message
        send(8'h80, 0, 1); send(8'h3C, 0, 1);
        rst_n = 1'b0; @(posedge clk); #1 rst_n = 1'b1;
        send(8'h40, 0, 0);
        check("t6.no_evt", a_valid, 1'b0);
        check("t6.LED", a_led, 8'h00);
        check("t6.note", a_note, 7'h00);
        check("t6.err_cnt", a_err, 8'h00);

        // randomized traffic, checked by the compare process
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0; @(posedge clk); #1 rst_n = 1'b1;
            end
            send(rand_byte(), ($urandom_range(0, 49) == 0), $urandom_range(0, 2));
        end

        // error counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) send(8'h00, 1, 0);
        check("t6.err_sat", a_err, 8'd255);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
